// File: rtl/traffic_pkg.sv
// Shared types and sizing helpers for the multi-direction intersection controller.
package traffic_pkg;

  typedef enum logic [1:0] {LT_OFF, LT_RED, LT_YELLOW, LT_GREEN} light_t;

  typedef enum logic [2:0] {S_GREEN, S_YELLOW, S_ALLRED, S_WALK, S_FLASH} state_t;

  function automatic int max_cyc(input int a, input int b, input int c,
                                 input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

  // The timer holds at most DUR-1, so a duration of 1 or 2 still needs one bit.
  function automatic int cnt_width(input int max_dur);
    return (max_dur <= 2) ? 1 : $clog2(max_dur);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Down-counter used for phase durations and the flash blink half-period.
module phase_timer #(
  parameter int             W       = 3,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/traffic_ctrl_multi.sv
// N-direction round-robin intersection controller with latched pedestrian WALK
// and flashing-yellow maintenance mode. All outputs decode registered state.
module traffic_ctrl_multi
  import traffic_pkg::*;
#(
  parameter int NUM_DIR    = 2,
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 2,
  parameter int WALK_CYC   = 5,
  parameter int FLASH_CYC  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flash_en,
  input  logic [NUM_DIR-1:0]         ped_req,
  output light_t                     color [NUM_DIR],
  output logic                       walk,
  output logic [$clog2(NUM_DIR)-1:0] active_dir,
  output state_t                     dbg_state
);

  localparam int DW = $clog2(NUM_DIR);
  localparam int TW = cnt_width(max_cyc(GREEN_CYC, YELLOW_CYC, ALLRED_CYC,
                                        WALK_CYC, FLASH_CYC));

  localparam logic [TW-1:0] GREEN_LD  = TW'(GREEN_CYC - 1);
  localparam logic [TW-1:0] YELLOW_LD = TW'(YELLOW_CYC - 1);
  localparam logic [TW-1:0] ALLRED_LD = TW'(ALLRED_CYC - 1);
  localparam logic [TW-1:0] WALK_LD   = TW'(WALK_CYC - 1);
  localparam logic [TW-1:0] FLASH_LD  = TW'(FLASH_CYC - 1);
  localparam logic [DW-1:0] LAST_DIR  = DW'(NUM_DIR - 1);

  if (NUM_DIR < 2) begin : g_bad_num_dir
    $fatal(1, "traffic_ctrl_multi: NUM_DIR must be >= 2");
  end
  if (GREEN_CYC < 1 || YELLOW_CYC < 1 || ALLRED_CYC < 1 ||
      WALK_CYC < 1 || FLASH_CYC < 1) begin : g_bad_cyc
    $fatal(1, "traffic_ctrl_multi: all *_CYC parameters must be >= 1");
  end

  state_t               state_q, state_d;
  logic [DW-1:0]        dir_q, dir_d, dir_next;
  logic [NUM_DIR-1:0]   pend_q, pend_d;
  logic                 blink_q, blink_d;
  logic                 tmr_load;
  logic [TW-1:0]        tmr_val;
  logic                 tmr_done;

  phase_timer #(
    .W       (TW),
    .RST_VAL (ALLRED_LD)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  assign dir_next = (dir_q == LAST_DIR) ? '0 : dir_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    pend_d   = pend_q | ped_req;
    blink_d  = blink_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (flash_en) begin
      // Flash overrides everything; in flash the timer paces the blink instead.
      pend_d = '0;
      if (state_q != S_FLASH) begin
        state_d  = S_FLASH;
        blink_d  = 1'b1;
        tmr_load = 1'b1;
        tmr_val  = FLASH_LD;
      end else if (tmr_done) begin
        blink_d  = ~blink_q;
        tmr_load = 1'b1;
        tmr_val  = FLASH_LD;
      end
    end else begin
      case (state_q)
        S_GREEN: begin
          if (tmr_done) begin
            state_d  = S_YELLOW;
            tmr_load = 1'b1;
            tmr_val  = YELLOW_LD;
          end
        end
        S_YELLOW: begin
          if (tmr_done) begin
            state_d  = S_ALLRED;
            tmr_load = 1'b1;
            tmr_val  = ALLRED_LD;
          end
        end
        S_ALLRED: begin
          if (tmr_done) begin
            tmr_load = 1'b1;
            if ((pend_q | ped_req) != '0) begin
              state_d = S_WALK;
              tmr_val = WALK_LD;
              pend_d  = '0;
            end else begin
              state_d = S_GREEN;
              tmr_val = GREEN_LD;
              dir_d   = dir_next;
            end
          end
        end
        S_WALK: begin
          if (tmr_done) begin
            state_d  = S_GREEN;
            tmr_load = 1'b1;
            tmr_val  = GREEN_LD;
            dir_d    = dir_next;
          end
        end
        S_FLASH: begin
          state_d  = S_ALLRED;
          tmr_load = 1'b1;
          tmr_val  = ALLRED_LD;
          pend_d   = '0;
        end
        default: begin
          state_d  = S_ALLRED;
          tmr_load = 1'b1;
          tmr_val  = ALLRED_LD;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ALLRED;
      dir_q   <= LAST_DIR;
      pend_q  <= '0;
      blink_q <= 1'b1;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      blink_q <= blink_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_DIR; i++) begin
      color[i] = LT_RED;
      if (state_q == S_FLASH) begin
        color[i] = blink_q ? LT_YELLOW : LT_OFF;
      end else if (DW'(i) == dir_q) begin
        if (state_q == S_GREEN)  color[i] = LT_GREEN;
        if (state_q == S_YELLOW) color[i] = LT_YELLOW;
      end
    end
  end

  assign walk       = (state_q == S_WALK);
  assign active_dir = dir_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Directed bench for traffic_ctrl_multi: a 2-direction and a 3-direction instance.
// Cycle n is observed on the falling edge just before rising edge n.
module tb_traffic_ctrl_multi;
  import traffic_pkg::*;

  // {color[1], color[0]} encodings, LT_OFF=0 LT_RED=1 LT_YELLOW=2 LT_GREEN=3
  localparam logic [3:0] RR  = 4'b0101;
  localparam logic [3:0] G0  = 4'b0111;
  localparam logic [3:0] Y0  = 4'b0110;
  localparam logic [3:0] G1  = 4'b1101;
  localparam logic [3:0] Y1  = 4'b1001;
  localparam logic [3:0] YY  = 4'b1010;
  localparam logic [3:0] OFF = 4'b0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         flash_en = 1'b0;
  logic [1:0]   ped_req = '0;
  light_t       color [2];
  logic         walk;
  logic [0:0]   active_dir;
  state_t       dbg_state;

  logic         rst3 = 1'b1;
  logic         flash3 = 1'b0;
  logic [2:0]   ped3 = '0;
  light_t       color3 [3];
  logic         walk3;
  logic [1:0]   dir3;
  state_t       dbg3;

  traffic_ctrl_multi dut (
    .clk        (clk),
    .rst        (rst),
    .flash_en   (flash_en),
    .ped_req    (ped_req),
    .color      (color),
    .walk       (walk),
    .active_dir (active_dir),
    .dbg_state  (dbg_state)
  );

  traffic_ctrl_multi #(.NUM_DIR(3)) dut3 (
    .clk        (clk),
    .rst        (rst3),
    .flash_en   (flash3),
    .ped_req    (ped3),
    .color      (color3),
    .walk       (walk3),
    .active_dir (dir3),
    .dbg_state  (dbg3)
  );

  // ---------------- scoreboard ----------------
  int         n_chk  = 0;
  int         n_pass = 0;
  int         cyc    = 0;
  logic [3:0] exp_q[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
  endtask

  function automatic logic [3:0] col2();
    return {color[1], color[0]};
  endfunction

  task automatic push_seg(input int n, input logic [3:0] v);
    repeat (n) exp_q.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic goto(input int c);
    while (cyc < c) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    flash_en = 1'b0;
    ped_req = '0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  // One-cycle reset with the other inputs deliberately busy.
  task automatic pulse_reset();
    rst = 1'b1;
    flash_en = 1'b1;
    ped_req = 2'b11;
    @(negedge clk);
    rst = 1'b0;
    flash_en = 1'b0;
    ped_req = '0;
    cyc = 0;
  endtask

  // At most one non-RED direction on the 3-way instance, every cycle.
  always @(negedge clk) begin
    int nr;
    if (!rst3) begin
      nr = 0;
      for (int i = 0; i < 3; i++) if (color3[i] != LT_RED) nr++;
      n_chk++;
      assert (nr <= 1) n_pass++;
      else $error("FAIL inv3_one_nonred: observed %0d non-RED expected <=1", nr);
    end
  end

  initial begin
    // ---- test 1: reset state and basic round-robin ----
    do_reset(2);
    chk("t1_rst_color", col2(), RR);
    chk("t1_rst_walk", walk, 1'b0);
    chk("t1_rst_dir", active_dir, 1'b1);
    push_seg(2, RR); push_seg(8, G0); push_seg(3, Y0); push_seg(2, RR);
    push_seg(8, G1); push_seg(3, Y1); push_seg(2, RR); push_seg(1, G0);
    for (int c = 0; c <= 28; c++) begin
      goto(c);
      chk("t1_seq", col2(), exp_q.pop_front());
      if (c == 2 || c == 15) chk("t1_dir", active_dir, (c == 2) ? 1'b0 : 1'b1);
    end

    // ---- test 2: pedestrian pulse, second request during WALK ----
    do_reset(1);
    goto(4);  ped_req = 2'b10;
    goto(5);  ped_req = 2'b00;
    goto(13); chk("t2_ar13", col2(), RR); chk("t2_nowalk13", walk, 1'b0);
    goto(14); chk("t2_ar14", col2(), RR);
    goto(15); chk("t2_walk15", walk, 1'b1); chk("t2_red15", col2(), RR);
    goto(16); ped_req = 2'b01;
    goto(17); ped_req = 2'b00;
    goto(19); chk("t2_walk19", walk, 1'b1);
    goto(20); chk("t2_g20", col2(), G1); chk("t2_walkoff20", walk, 1'b0);
    chk("t2_dir20", active_dir, 1'b1);
    goto(27); chk("t2_g27", col2(), G1);
    goto(28); chk("t2_y28", col2(), Y1);
    goto(32); chk("t2_ar32", col2(), RR); chk("t2_nowalk32", walk, 1'b0);
    goto(33); chk("t2_walk33", walk, 1'b1);
    goto(37); chk("t2_walk37", walk, 1'b1);
    goto(38); chk("t2_g38", col2(), G0); chk("t2_dir38", active_dir, 1'b0);

    // ---- test 3: flash mode blink and exit ----
    do_reset(1);
    goto(5);  flash_en = 1'b1;
    goto(5);  chk("t3_g5", col2(), G0);
    goto(6);  chk("t3_y6", col2(), YY);  chk("t3_nowalk6", walk, 1'b0);
    goto(9);  chk("t3_y9", col2(), YY);
    goto(10); chk("t3_off10", col2(), OFF);
    goto(13); chk("t3_off13", col2(), OFF);
    goto(14); chk("t3_y14", col2(), YY);
    goto(18); chk("t3_off18", col2(), OFF);
    goto(20); chk("t3_off20", col2(), OFF); flash_en = 1'b0;
    goto(21); chk("t3_ar21", col2(), RR);
    goto(22); chk("t3_ar22", col2(), RR);
    goto(23); chk("t3_g23", col2(), G1); chk("t3_dir23", active_dir, 1'b1);

    // ---- test 4: flash discards pending and in-flash requests ----
    do_reset(1);
    goto(4);  ped_req = 2'b01;
    goto(5);  ped_req = 2'b00;
    goto(6);  flash_en = 1'b1;
    goto(8);  ped_req = 2'b10;
    goto(9);  ped_req = 2'b00;
    goto(10); flash_en = 1'b0;
    goto(12); chk("t4_ar12", col2(), RR); chk("t4_nowalk12", walk, 1'b0);
    goto(13); chk("t4_g13", col2(), G1); chk("t4_nowalk13", walk, 1'b0);
    goto(25); chk("t4_ar25", col2(), RR);
    goto(26); chk("t4_g26", col2(), G0); chk("t4_nowalk26", walk, 1'b0);

    // ---- test 5: reset mid-YELLOW, then the startup sequence repeats ----
    do_reset(1);
    goto(11); chk("t5_y11", col2(), Y0);
    pulse_reset();
    chk("t5_rst_color", col2(), RR);
    chk("t5_rst_walk", walk, 1'b0);
    chk("t5_rst_dir", active_dir, 1'b1);
    goto(1);  chk("t5_ar1", col2(), RR);
    goto(2);  chk("t5_g2", col2(), G0);
    goto(9);  chk("t5_g9", col2(), G0);
    goto(10); chk("t5_y10", col2(), Y0);
    goto(15); chk("t5_g15", col2(), G1); chk("t5_nowalk15", walk, 1'b0);

    // ---- test 6: three directions, wrap 2 -> 0 ----
    rst = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    cyc = 0;
    chk("t6_rst_dir", dir3, 2'd2);
    goto(2);  chk("t6_g0", color3[0], LT_GREEN); chk("t6_dir0", dir3, 2'd0);
    goto(15); chk("t6_g1", color3[1], LT_GREEN); chk("t6_dir1", dir3, 2'd1);
    goto(28); chk("t6_g2", color3[2], LT_GREEN); chk("t6_dir2", dir3, 2'd2);
    goto(38); chk("t6_y2", color3[2], LT_YELLOW);
    goto(41); chk("t6_g0_wrap", color3[0], LT_GREEN); chk("t6_dir_wrap", dir3, 2'd0);
    chk("t6_nowalk", walk3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
